// File: rtl/mem_port_arbiter_if.sv
// Two cache-controller request ports, the shared memory port and arbiter status.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              req0_read;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [LINE_W-1:0] req0_wdata;
  logic [LINE_W-1:0] req0_rdata;
  logic              req0_resp;

  logic              req1_read;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [LINE_W-1:0] req1_wdata;
  logic [LINE_W-1:0] req1_rdata;
  logic              req1_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  logic              owner;
  logic              busy;
  logic              protocol_err;

  modport master (
    input  req0_read, req0_write, req0_addr, req0_wdata,
    output req0_rdata, req0_resp,
    input  req1_read, req1_write, req1_addr, req1_wdata,
    output req1_rdata, req1_resp,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp,
    output owner, busy, protocol_err
  );

  modport slave (
    output req0_read, req0_write, req0_addr, req0_wdata,
    input  req0_rdata, req0_resp,
    output req1_read, req1_write, req1_addr, req1_wdata,
    input  req1_rdata, req1_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp,
    input  owner, busy, protocol_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between two level-held requesters; grant->strobe 1 cycle, mem_resp->reqN_resp 1 cycle.
// Requests are held by the requester until resp; define MEM_ARB_ROUND_ROBIN_EN for round-robin contention (else port 0 wins).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_owner;
  logic              r_busy;
  logic              r_perr;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_resp0;
  logic              r_resp1;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_rdata;

  logic              w_req0;
  logic              w_req1;
  logic              w_win;
  logic              w_grant;
  logic              w_complete;
  logic              w_stray;
  logic              w_dual;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LINE_W-1:0] w_sel_wdata;

  assign w_req0 = bus.req0_read | bus.req0_write;
  assign w_req1 = bus.req1_read | bus.req1_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  // Pointer starts at 0 so port 1 takes the first contention after reset.
  assign w_win = (w_req0 & w_req1) ? ~r_last : w_req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b0;
    end else if (w_grant) begin
      r_last <= w_win;
    end
  end
`else
  assign w_win = w_req1 & ~w_req0;
`endif

  // Read+write together on the winner is issued as a write.
  assign w_sel_write = w_win ? bus.req1_write : bus.req0_write;
  assign w_sel_addr  = w_win ? bus.req1_addr  : bus.req0_addr;
  assign w_sel_wdata = w_win ? bus.req1_wdata : bus.req0_wdata;
  assign w_dual      = w_win ? (bus.req1_read & bus.req1_write)
                             : (bus.req0_read & bus.req0_write);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_complete = 1'b0;
    w_stray    = bus.mem_resp;
    case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_stray = 1'b0;
        if (bus.mem_resp) begin
          w_complete = 1'b1;
          w_next     = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= 1'b0;
      r_busy      <= 1'b0;
      r_perr      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_resp0     <= 1'b0;
      r_resp1     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      r_perr  <= (w_grant & w_dual) | w_stray;
      r_resp0 <= 1'b0;
      r_resp1 <= 1'b0;
      if (w_grant) begin
        r_owner     <= w_win;
        r_addr      <= w_sel_addr;
        r_wdata     <= w_sel_wdata;
        r_mem_write <= w_sel_write;
        r_mem_read  <= ~w_sel_write;
        r_busy      <= 1'b1;
      end
      if (w_complete) begin
        r_rdata     <= bus.mem_rdata;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_resp0     <= ~r_owner;
        r_resp1     <= r_owner;
      end
      if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign bus.mem_read     = r_mem_read;
  assign bus.mem_write    = r_mem_write;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.req0_resp    = r_resp0;
  assign bus.req1_resp    = r_resp1;
  assign bus.req0_rdata   = r_resp0 ? r_rdata : '0;
  assign bus.req1_rdata   = r_resp1 ? r_rdata : '0;
  assign bus.owner        = r_owner;
  assign bus.busy         = r_busy;
  assign bus.protocol_err = r_perr;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single physical-memory port between two cache controllers, for example the instruction-cache and data-cache instances of the two-way cache controller. It accepts level-held line read and write requests, grants one requester at a time and drives the memory port from registered copies of the granted request. It returns the memory response and read line to the winner.

## Interface
Parameters:
- ADDR_W, 32, line address width
- LINE_W, 256, cache line width in bits

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req0_read  in  1  port 0 line-fetch request, held until req0_resp
- req0_write  in  1  port 0 write-back request, held until req0_resp
- req0_addr  in  ADDR_W  port 0 line address
- req0_wdata  in  LINE_W  port 0 write-back line
- req0_rdata  out  LINE_W  port 0 fetched line, valid while req0_resp=1
- req0_resp  out  1  port 0 completion pulse
- req1_read, req1_write, req1_addr, req1_wdata, req1_rdata, req1_resp: same as port 0, for port 1
- mem_read  out  1  memory read strobe, held until mem_resp
- mem_write  out  1  memory write strobe, held until mem_resp
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write line
- mem_rdata  in  LINE_W  memory read line, valid with mem_resp
- mem_resp  in  1  memory completion, 1 cycle
- owner  out  1  port currently granted, meaningful when busy=1
- busy  out  1  transaction in flight, states ISSUE and DONE
- protocol_err  out  1  1-cycle pulse on a protocol violation

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - A port is requesting when its read or write input is 1.
  - On any request, the block selects a winner and latches the winner's op, addr and wdata into registers.
  - It sets owner to the winner and moves to ISSUE.
  - With no request, it stays in IDLE.
- ISSUE:
  - Drives mem_read or mem_write, mem_addr and mem_wdata from the latched registers.
  - Held until mem_resp=1.
  - On mem_resp=1, the block registers mem_rdata, drops the strobe on the next cycle and moves to DONE.
- DONE:
  - Asserts reqN_resp for owner N for exactly one cycle.
  - reqN_rdata carries the registered line during that cycle. The registered line is driven on writes too, and its content is don't-care.
  - The non-owner's resp stays 0 and its rdata is 0.
  - Moves to IDLE unconditionally.
- Requester contract: a requester deasserts read and write in the cycle after it sees resp. IDLE therefore never re-grants a completed request.
- Selection with a single requester: that port wins.
- Selection with both ports requesting: governed by the Configuration section.
- read=1 and write=1 on the same port at sampling:
  - Treated as write.
  - protocol_err pulses in the following cycle.
- mem_resp while not in ISSUE:
  - Ignored.
  - protocol_err pulses in the next cycle.
- Requests arriving or changing while busy are ignored until the next IDLE. Latched values are not updated mid-transaction.
- Reset, asynchronous and honoured at any point including mid-ISSUE:
  - State returns to IDLE.
  - The in-flight transaction is abandoned, with no resp.
  - All outputs are 0: mem_read, mem_write, mem_addr, mem_wdata, req0/1_rdata, req0/1_resp, owner, busy, protocol_err.
  - The round-robin pointer, if compiled in, resets to 0.

## Timing
- Request sampled in IDLE at cycle 0.
- mem_read or mem_write is high from cycle 1.
- If mem_resp arrives in cycle k (k≥1), then:
  - the strobe is low in cycle k+1;
  - reqN_resp and rdata are valid in cycle k+1;
  - IDLE is reached in cycle k+2.
- Minimum transaction with k=1: request at cycle 0, resp at cycle 2, next grant sampled at cycle 3. Back-to-back grants are separated by at least 3 cycles.
- mem_addr and mem_wdata are stable for the whole ISSUE duration.
- There is no combinational path from any input to mem_* or reqN_resp; every output comes from a register.

## Configuration
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant register is updated on every grant.
  - When both ports request in IDLE, the port not granted last wins.
  - After reset, port 1 wins the first contention.
- Undefined:
  - Fixed priority applies: port 0 always wins contention.
  - No pointer register exists.
  - Port 1 can starve under continuous port 0 traffic, and this is accepted.

## Test plan
- Port 0 read only, addr=0x40, memory responds at k=3 with line 0xA5..A5:
  - mem_read is high in cycles 1-3 with mem_addr=0x40.
  - req0_resp=1 and req0_rdata=0xA5..A5 in cycle 4.
  - req1_resp stays 0.
- Port 1 write, addr=0x80, wdata=0x1234, mem_resp at k=1:
  - mem_write=1 with mem_wdata=0x1234 in cycle 1.
  - req1_resp in cycle 2.
  - busy low in cycle 3.
- Both ports request reads on the same cycle, held continuously, each completing before re-requesting:
  - With MEM_ARB_ROUND_ROBIN_EN defined, owner sequence is 1,0,1,0.
  - With it undefined, owner stays 0 for all 4 grants.
- Port 0 asserts read and write together:
  - Write is issued.
  - protocol_err pulses once in cycle 1.
- Stray mem_resp in IDLE:
  - protocol_err pulses for 1 cycle.
  - No reqN_resp.
  - State stays IDLE.
- rst driven to 0 mid-ISSUE, asynchronously between clock edges:
  - All outputs read 0 immediately.
  - No resp is ever issued for the abandoned request.
  - A fresh request after rst returns to 1 completes normally.
